// File: rtl/sprite_pos_accum.sv
// sprite_pos_accum
// Holds the signed X/Y position of one sprite. It accepts LOAD/ADD/SUB/CLRFLAG
// commands over a valid/ready handshake and runs each one through a two's-
// complement add/sub datapath. The result is optionally saturated, written back
// to the selected axis, and returned with carry/overflow status over a second
// valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; ready only while idle
//   cmd_op                 00 LOAD, 01 ADD, 10 SUB, 11 CLRFLAG
//   cmd_axis               0 = X, 1 = Y
//   cmd_data               load value or signed delta
//   rsp_valid/rsp_ready    response handshake
//   rsp_data               coordinate after the command
//   rsp_carry, rsp_ovf     raw adder carry-out and signed overflow (pre-saturation)
//   ovf_sticky             OR of rsp_ovf since reset or last CLRFLAG
//   pos_x, pos_y           current position registers
module sprite_pos_accum #(
  parameter int               WIDTH    = 16,
  parameter bit               SATURATE = 1'b1,
  parameter logic [WIDTH-1:0] X_RESET  = '0,
  parameter logic [WIDTH-1:0] Y_RESET  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_axis,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] pos_x,
  output logic [WIDTH-1:0] pos_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [1:0]       op_q;
  logic             axis_q;
  logic [WIDTH-1:0] data_q;

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             sub_mode;
  logic [WIDTH:0]   sum_ext;
  logic             c_msb;
  logic             c_into_msb;
  logic             add_ovf;
  logic [WIDTH-1:0] result;
  logic             res_carry;
  logic             res_ovf;

  assign cmd_ready = (state == IDLE);

  // Add/sub datapath: mode 1 computes A + ~B + 1. Overflow is the carry out of
  // the MSB XOR the carry into it. The carry into the MSB is recovered as
  // a^b^sum at the top bit.
  always_comb begin
    a_sel      = axis_q ? pos_y : pos_x;
    sub_mode   = (op_q == OP_SUB);
    b_sel      = sub_mode ? ~data_q : data_q;
    sum_ext    = {1'b0, a_sel} + {1'b0, b_sel} + {{WIDTH{1'b0}}, sub_mode};
    c_msb      = sum_ext[WIDTH];
    c_into_msb = a_sel[WIDTH-1] ^ b_sel[WIDTH-1] ^ sum_ext[WIDTH-1];
    add_ovf    = c_msb ^ c_into_msb;

    result    = sum_ext[WIDTH-1:0];
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (op_q)
      OP_LOAD: result = data_q;
      OP_CLR:  result = a_sel;
      default: begin
        res_carry = c_msb;
        res_ovf   = add_ovf;
        // A wrapped sum has the wrong sign, so a negative-looking sum came
        // from a positive overflow and must clamp to the positive limit.
        if (SATURATE && add_ovf)
          result = sum_ext[WIDTH-1] ? MAX_POS : MIN_NEG;
      end
    endcase
  end

  // Command sequencer. Every output except cmd_ready is registered here, so a
  // reset at any point abandons the command without partial writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_LOAD;
      axis_q     <= 1'b0;
      data_q     <= '0;
      pos_x      <= X_RESET;
      pos_y      <= Y_RESET;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            axis_q <= cmd_axis;
            data_q <= cmd_data;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (axis_q)
            pos_y <= result;
          else
            pos_x <= result;
          rsp_data  <= result;
          rsp_carry <= res_carry;
          rsp_ovf   <= res_ovf;
          if (op_q == OP_CLR)
            ovf_sticky <= 1'b0;
          else
            ovf_sticky <= ovf_sticky | res_ovf;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sprite_pos_accum.md
Name: sprite_pos_accum

Overview:
- Sequential consumer and driver of the 16-bit two's-complement add/sub datapath: mode 0 = A+B, mode 1 = A+~B+1, carry = c16, overflow = c16^c15.
- Holds the signed X and Y position registers for one sprite.
- Accepts move and load commands over a valid/ready handshake. Runs each command through the add/sub datapath, then optionally saturates and writes the result back.
- Returns the new coordinate and status flags over a second valid/ready handshake. Sits between the sprite command decoder and the renderer.

Parameters:
- WIDTH, 16, coordinate and delta width in bits; signed two's complement.
- SATURATE, 1, 1 = clamp on signed overflow; 0 = wrap (keep raw sum).
- X_RESET, 16'h0000, X position value after reset.
- Y_RESET, 16'h0000, Y position value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLRFLAG.
- cmd_axis  in  1  0 = X, 1 = Y.
- cmd_data  in  WIDTH  load value or delta.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  coordinate after the command.
- rsp_carry  out  1  raw adder carry-out (c16) for this command.
- rsp_ovf  out  1  signed overflow for this command (before saturation).
- ovf_sticky  out  1  OR of all rsp_ovf since reset or the last CLRFLAG.
- pos_x  out  WIDTH  current X register.
- pos_y  out  WIDTH  current Y register.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, pos_x = X_RESET, pos_y = Y_RESET.
  - rsp_valid = 0, rsp_data = 0, rsp_carry = 0, rsp_ovf = 0, ovf_sticky = 0.
  - cmd_ready = 1 after release.
  - Reset mid-command abandons the command; no partial writeback.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1 (combinational from state).
  - On cmd_valid & cmd_ready: capture op, axis and data into operand registers; go to EXEC.
- EXEC (one cycle), cmd_ready = 0:
  - A = selected position register, B = captured data, mode = (op == SUB).
  - LOAD: result = data, carry = 0, ovf = 0.
  - CLRFLAG: result = current position, carry = 0, ovf = 0; ovf_sticky cleared this cycle.
  - ADD/SUB: ovf = c16^c15. If SATURATE and ovf, result = sum[WIDTH-1] ? max positive (7FFF) : min negative (8000). Otherwise result = sum.
  - Write result into the selected axis register; the other axis is untouched.
  - Register rsp_data, rsp_carry, rsp_ovf. ovf_sticky |= ovf (except CLRFLAG).
  - Set rsp_valid = 1; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid = 0 and go to IDLE. cmd_ready rises the following cycle; there is no same-cycle overlap.
- Latency: command accepted at cycle N. pos_* updated and rsp_valid high at cycle N+2 (visible after the N+1 edge registers). Throughput is at most 1 command per 3 cycles.
- cmd_data and cmd_op are ignored when cmd_ready = 0. No command is ever dropped or duplicated.
- rsp_carry for SUB follows A+~B+1: carry = 1 means no borrow.
- Back-pressure: rsp_ready held low stalls in RESP indefinitely with all outputs stable.

Test Plan:
- Reset with X_RESET = 0010 -> pos_x = 0010, pos_y = 0000, rsp_valid = 0, cmd_ready = 1; async assert mid-EXEC returns to these values immediately.
- LOAD X 7FF0, then ADD X 0020, SATURATE = 1 -> rsp_data = 7FFF, rsp_ovf = 1, rsp_carry = 0, ovf_sticky = 1, pos_x = 7FFF; rsp_valid rises two cycles after acceptance.
- LOAD Y 0005, SUB Y 0007 -> rsp_data = FFFE, carry = 0, ovf = 0. Then LOAD Y 8000, SUB Y 0001 -> 8000 with ovf = 1 (saturated); with SATURATE = 0 the result is 7FFF, ovf = 1.
- ADD X FFFF with pos_x = 0003 -> 0002, carry = 1, ovf = 0; pos_y unchanged.
- Hold rsp_ready = 0 for 5 cycles -> rsp_* stable, cmd_ready = 0, new cmd_valid ignored. Release -> one handshake, IDLE next cycle.
- CLRFLAG after an overflow -> ovf_sticky = 0, rsp_data = current position, positions unchanged.
